// File: rtl/rc4_xor_stream.sv
// Keystream XOR engine: prefetches keystream bytes into a small FIFO and XORs them with the input stream.
// Define RC4_XOR_DROP_EN to discard the first DROP_COUNT keystream bytes of every session.
module rc4_xor_stream #(
  parameter int KS_DEPTH   = 4,
  parameter int DROP_COUNT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] length,
  input  logic        ks_valid,
  input  logic [7:0]  ks_data,
  output logic        ks_ready,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);
  localparam int AW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam int CW = $clog2(KS_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(KS_DEPTH);

`ifdef RC4_XOR_DROP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DROP = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;
  localparam logic [15:0] DROP_LAST = 16'(DROP_COUNT - 1);
  logic [15:0] drop_cnt_q, drop_cnt_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd2, DRAIN = 2'd3} state_t;
`endif

  state_t          state_q, state_d;
  logic [15:0]     rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            done_q, done_d;
  logic [7:0]      ks_mem_q [KS_DEPTH];

  logic            in_xfer;
  logic            ks_xfer;
  logic            push;
  logic            fifo_room;
  logic            fetch_ok;
  logic [7:0]      ks_head;

  always_comb begin
    ks_head   = ks_mem_q[rd_ptr_q];
    in_ready  = (state_q == RUN) && (cnt_q != '0) && (!out_valid_q || out_ready);
    in_xfer   = in_valid && in_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a byte.
    fifo_room = (cnt_q != FULL_CNT) || in_xfer;
    fetch_ok  = 16'(cnt_q) < rem_q;
    ks_ready  = (state_q == RUN) && fifo_room && fetch_ok;
`ifdef RC4_XOR_DROP_EN
    if (state_q == DROP) ks_ready = 1'b1;
`endif
    ks_xfer   = ks_valid && ks_ready;
    push      = ks_xfer && (state_q == RUN);

    state_d     = state_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
`ifdef RC4_XOR_DROP_EN
    drop_cnt_d  = drop_cnt_q;
`endif

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (in_xfer) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      rem_d       = rem_q - 16'd1;
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ ks_head;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    cnt_d = cnt_q + CW'(push) - CW'(in_xfer);

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d = length;
          if (length == 16'd0) begin
            done_d = 1'b1;
          end else begin
`ifdef RC4_XOR_DROP_EN
            state_d    = DROP;
            drop_cnt_d = 16'd0;
`else
            state_d    = RUN;
`endif
          end
        end
      end
`ifdef RC4_XOR_DROP_EN
      DROP: begin
        if (ks_xfer) begin
          if (drop_cnt_q == DROP_LAST) state_d = RUN;
          else drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
`endif
      RUN: begin
        if (in_xfer && rem_q == 16'd1) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any leftover prefetched keystream is dropped whenever the block is idle.
    if (state_d == IDLE) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= 16'd0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      done_q      <= 1'b0;
`ifdef RC4_XOR_DROP_EN
      drop_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
`ifdef RC4_XOR_DROP_EN
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) ks_mem_q[wr_ptr_q] <= ks_data;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
endmodule

// File: tb/tb_rc4_xor_stream.sv
// Directed bench for rc4_xor_stream; queue-driven ks/in sources and an output collector.
module tb_rc4_xor_stream;
`ifdef RC4_XOR_DROP_EN
  localparam int TB_DROP = 4;
`else
  localparam int TB_DROP = 256;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] length = 16'd0;
  logic        ks_valid = 1'b0;
  logic [7:0]  ks_data = 8'd0;
  logic        ks_ready;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  rc4_xor_stream #(.KS_DEPTH(4), .DROP_COUNT(TB_DROP)) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] ks_q[$];
  logic [7:0] in_q[$];
  logic [7:0] got_q[$];
  bit out_ready_en = 1'b0;
  bit ks_rdy_seen, in_rdy_seen;
  int cyc, done_cnt, ks_fired, in_fired, max_occ, last_out_cyc, done_cyc;
  int n_checks = 0;
  int n_errors = 0;

  // Drive sources at the falling edge, then record which handshakes will fire at the next rising edge.
  always @(negedge clk) begin
    ks_valid  = (ks_q.size() > 0);
    ks_data   = ks_valid ? ks_q[0] : 8'h00;
    in_valid  = (in_q.size() > 0);
    in_data   = in_valid ? in_q[0] : 8'h00;
    out_ready = out_ready_en;
    #1;
    cyc++;
    if (ks_ready) ks_rdy_seen = 1'b1;
    if (in_ready) in_rdy_seen = 1'b1;
    if (ks_valid && ks_ready) begin void'(ks_q.pop_front()); ks_fired++; end
    if (in_valid && in_ready) begin void'(in_q.pop_front()); in_fired++; end
    if (out_valid && out_ready) begin got_q.push_back(out_data); last_out_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (ks_fired - in_fired > max_occ) max_occ = ks_fired - in_fired;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_stats();
    ks_q.delete(); in_q.delete(); got_q.delete();
    ks_fired = 0; in_fired = 0; max_occ = 0;
    ks_rdy_seen = 1'b0; in_rdy_seen = 1'b0;
  endtask

  task automatic start_session(input logic [15:0] len);
    step();
    start  = 1'b1;
    length = len;
    step();
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin step(); n++; end
    check_val(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  logic [7:0] exp36 [8] = '{8'hF0, 8'hE0, 8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'h90, 8'h80};

  initial begin
    int d0;
    int n;
    // Reset state
    repeat (3) step();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_ks_ready", 32'(ks_ready), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();
    out_ready_en = 1'b1;

`ifdef RC4_XOR_DROP_EN
    // Drop 4 bytes, then XOR zeros with the remaining keystream
    clear_stats();
    for (int i = 1; i <= 9; i++) ks_q.push_back(8'(i));
    for (int i = 0; i < 5; i++) in_q.push_back(8'h00);
    d0 = done_cnt;
    start_session(16'd5);
    wait_done("drop_done", 60, d0);
    check_val("drop_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      $display("drop out[%0d] = %0h", i, got_q[i]);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      check_val("drop_out", 32'(got_q[i]), 32'(i + 5));
`else
    // Basic length-3 session; an extra keystream byte must not be fetched
    clear_stats();
    ks_q = '{8'h5A, 8'hA5, 8'hFF, 8'h77};
    in_q = '{8'h00, 8'h0F, 8'hFF};
    d0 = done_cnt;
    start_session(16'd3);
    wait_done("basic_done", 40, d0);
    check_val("basic_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      $display("basic outs %0h %0h %0h", got_q[0], got_q[1], got_q[2]);
      check_val("basic_out0", 32'(got_q[0]), 32'h5A);
      check_val("basic_out1", 32'(got_q[1]), 32'hAA);
      check_val("basic_out2", 32'(got_q[2]), 32'h00);
    end
    check_val("basic_done_lat", 32'(done_cyc - last_out_cyc), 32'd1);
    check_val("basic_no_overfetch", 32'(ks_fired), 32'd3);
    step();
    check_val("basic_idle", 32'(busy), 32'd0);
`endif

    // Zero-length session
    clear_stats();
    d0 = done_cnt;
    start_session(16'd0);
    $display("len0 done=%0b busy=%0b", done, busy);
    check_val("len0_done", 32'(done), 32'd1);
    check_val("len0_busy", 32'(busy), 32'd0);
    step();
    check_val("len0_pulse", 32'(done), 32'd0);
    check_val("len0_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_val("len0_ks_ready", 32'(ks_rdy_seen), 32'd0);
    check_val("len0_in_ready", 32'(in_rdy_seen), 32'd0);

    // Length 8 with a 5-cycle downstream stall mid-stream
    clear_stats();
    for (int i = 0; i < 8; i++) begin
      ks_q.push_back(8'hF0 + 8'(i));
      in_q.push_back(8'h11 * 8'(i));
    end
    d0 = done_cnt;
    start_session(16'd8);
    repeat (4) step();
    out_ready_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("stall_valid", 32'(out_valid), 32'd1);
      if (got_q.size() < 8) check_val("stall_hold", 32'(out_data), 32'(exp36[got_q.size()]));
    end
    out_ready_en = 1'b1;
    wait_done("stall_done", 60, d0);
    check_val("stall_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      check_val("stall_out", 32'(got_q[i]), 32'(exp36[i]));
    check_val("stall_fifo_max", 32'(max_occ), 32'd4);
    check_val("stall_ks_fetched", 32'(ks_fired), 32'd8);
    $display("stall session: %0d outputs, fifo peak %0d", got_q.size(), max_occ);

    // Reset in the middle of a 6-byte session
    clear_stats();
    for (int i = 1; i <= 6; i++) begin ks_q.push_back(8'(i)); in_q.push_back(8'h00); end
    d0 = done_cnt;
    start_session(16'd6);
    n = 0;
    while (got_q.size() < 2 && n < 40) begin step(); n++; end
    check_val("abort_progress", 32'(got_q.size() >= 2), 32'd1);
    rst = 1'b1;
    step();
    check_val("abort_out_valid", 32'(out_valid), 32'd0);
    check_val("abort_out_data", 32'(out_data), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_ks_ready", 32'(ks_ready), 32'd0);
    check_val("abort_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    clear_stats();
    repeat (3) step();
    check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);
    ks_q = '{8'h3C};
    in_q = '{8'hC3};
    d0 = done_cnt;
    start_session(16'd1);
    wait_done("after_abort_done", 30, d0);
    check_val("after_abort_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check_val("after_abort_out", 32'(got_q[0]), 32'hFF);

    // Start while busy must be ignored
    clear_stats();
    out_ready_en = 1'b0;
    ks_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    in_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    d0 = done_cnt;
    start_session(16'd2);
    repeat (3) step();
    start_session(16'd5);
    check_val("busy_during", 32'(busy), 32'd1);
    out_ready_en = 1'b1;
    wait_done("busy_done", 40, d0);
    repeat (4) step();
    check_val("busy_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      check_val("busy_out0", 32'(got_q[0]), 32'h10);
      check_val("busy_out1", 32'(got_q[1]), 32'h20);
    end
    check_val("busy_ks_fetched", 32'(ks_fired), 32'd2);
    check_val("busy_in_taken", 32'(in_fired), 32'd2);
    check_val("busy_idle_after", 32'(busy), 32'd0);
    clear_stats();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rc4_xor_stream.md
RC4_XOR_STREAM -- requirements
Module: rc4_xor_stream

Interface
REQ-001 SHALL have parameter KS_DEPTH, default 4, keystream prefetch FIFO depth in bytes; power of two, 2..16.
REQ-002 SHALL have parameter DROP_COUNT, default 256, keystream bytes discarded per session; used only when RC4_XOR_DROP_EN is defined.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle session start, accepted only in IDLE.
REQ-006 SHALL have port length  input  16  session byte count, sampled when start is accepted.
REQ-007 SHALL have port ks_valid  input  1  keystream byte valid from generator.
REQ-008 SHALL have port ks_data  input  8  keystream byte.
REQ-009 SHALL have port ks_ready  output  1  block accepts keystream byte this cycle.
REQ-010 SHALL have port in_valid  input  1  plaintext/ciphertext byte valid.
REQ-011 SHALL have port in_data  input  8  input byte.
REQ-012 SHALL have port in_ready  output  1  block accepts input byte this cycle.
REQ-013 SHALL have port out_valid  output  1  result byte valid.
REQ-014 SHALL have port out_data  output  8  result byte, in_data XOR keystream.
REQ-015 SHALL have port out_ready  input  1  downstream accepts result.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse when the last result byte is accepted downstream.

Function
REQ-018 SHALL transfer a byte on any channel only in a cycle with valid and ready both high.
REQ-019 SHALL implement FSM IDLE -> (DROP) -> RUN -> DRAIN -> IDLE.
REQ-020 SHALL on start in IDLE load remaining=length and go to DROP if RC4_XOR_DROP_EN is defined, else to RUN.
REQ-021 SHALL on start with length=0 skip RUN, pulse done the next cycle and return to IDLE.
REQ-022 SHALL drive ks_ready = (FIFO not full) AND (state is DROP or RUN) AND (keystream bytes fetched < remaining bytes still to pair); never over-fetch past the session length.
REQ-023 SHALL drive in_ready = (state RUN) AND (FIFO not empty) AND (output register empty OR out_ready).
REQ-024 SHALL on each input transfer pop one FIFO byte, register out_data = in_data XOR popped byte, set out_valid, and decrement remaining, all in that same edge; latency is 1 cycle input-to-output.
REQ-025 SHALL hold out_valid and out_data stable until out_ready; with out_ready held high, sustain one byte per cycle.
REQ-026 SHALL accept a keystream push and a pop in the same cycle when the FIFO is full, with no loss.
REQ-027 SHALL go RUN -> DRAIN when remaining reaches 0, and DRAIN -> IDLE when the final output is accepted; done pulses in that cycle.
REQ-028 SHALL ignore start while busy.
REQ-029 SHALL wrap FIFO pointers modulo KS_DEPTH and flush the FIFO on entry to IDLE.

Reset
REQ-030 SHALL on rst high at a rising edge force state IDLE, FIFO empty, remaining=0, out_valid=0, out_data=0, done=0, busy=0, ks_ready=0, in_ready=0.
REQ-031 SHALL abandon an in-progress session on reset without emitting done; reset overrides start in the same cycle.

Configuration
REQ-032 SHALL, with RC4_XOR_DROP_EN defined, implement state DROP: accept and discard exactly DROP_COUNT keystream bytes (ks_ready high whenever ks_valid may transfer), then enter RUN with the FIFO empty.
REQ-033 SHALL, without RC4_XOR_DROP_EN, omit DROP state and counter logic; DROP_COUNT has no effect.

Verification
REQ-034 SHALL cover: macro off, length=3, keystream 8'h5A,8'hA5,8'hFF, input 8'h00,8'h0F,8'hFF, out_ready=1 -> outputs 8'h5A,8'hAA,8'h00, done one cycle after third output.
REQ-035 SHALL cover: length=0 start -> done pulse next cycle, no ks_ready or in_ready assertion.
REQ-036 SHALL cover: length=8, out_ready low for 5 cycles mid-stream -> out_data held stable, no byte lost or duplicated, FIFO stops at KS_DEPTH=4 entries.
REQ-037 SHALL cover: macro on, DROP_COUNT=4, keystream 1..9, input all 8'h00, length=5 -> outputs 5,6,7,8,9.
REQ-038 SHALL cover: rst asserted after 2 of 6 bytes -> all outputs 0 next cycle, no done; new start with length=1 completes normally.
REQ-039 SHALL cover: start pulsed while busy -> ignored, session length unchanged.
